// File: rtl/ram_loader_pkg.sv
// Shared widths, length limit and FSM states for the 32x8 RAM loader.
package ram_loader_pkg;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned MAX_LEN = DEPTH;
  localparam int unsigned LEN_W   = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_DRAIN,
    S_VERIFY,
    S_DONE
  } state_t;
endpackage

// File: rtl/loader_addr_gen.sv
// Wrap-around RAM address counter with a remaining-count; serves both the write walk and the verify walk.
module loader_addr_gen
  import ram_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  count,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic [LEN_W-1:0]  remaining,
  output logic              last
);
  // 5-bit arithmetic gives the 31 -> 0 wrap for free
  assign next_addr = addr + ADDR_W'(1);
  assign last      = (remaining == LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base;
      remaining <= count;
    end else if (inc && remaining != '0) begin
      addr      <= next_addr;
      remaining <= remaining - LEN_W'(1);
    end
  end
endmodule

// File: rtl/ram_32x8_loader.sv
// Streams bytes from a valid/ready source into a 32x8 RAM at consecutive, wrapping addresses.
// Define LOADER_VERIFY_EN to add a read-back pass that compares XOR checksums of written and read data.
module ram_32x8_loader
  import ram_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              error
);
  state_t            state;
  logic [DATA_W-1:0] wchk;
  logic              accept;
  logic              ag_load, ag_inc, ag_last;
  logic [ADDR_W-1:0] ag_base, ag_addr, ag_next_addr;
  logic [LEN_W-1:0]  ag_count, ag_remaining;

`ifdef LOADER_VERIFY_EN
  logic [DATA_W-1:0] rchk, rchk_next;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;

  assign rchk_next = rchk ^ mem_rdata;
`else
  logic unused_bits;

  assign mem_re      = 1'b0;
  assign unused_bits = ^{mem_rdata, wchk};
`endif

  assign accept = din_valid && din_ready && (ag_remaining != '0);

  loader_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load      (ag_load),
    .inc       (ag_inc),
    .base      (ag_base),
    .count     (ag_count),
    .addr      (ag_addr),
    .next_addr (ag_next_addr),
    .remaining (ag_remaining),
    .last      (ag_last)
  );

  always_comb begin
    ag_load  = 1'b0;
    ag_inc   = 1'b0;
    ag_base  = base_addr;
    ag_count = length;
    case (state)
      S_IDLE, S_DONE: ag_load = start;
      S_WRITE:        ag_inc  = accept;
`ifdef LOADER_VERIFY_EN
      // Counter is reloaded in DRAIN so the verify walk starts at base again
      S_DRAIN: begin
        ag_load  = 1'b1;
        ag_base  = base_q;
        ag_count = len_q;
      end
      S_VERIFY:       ag_inc  = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      din_ready <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      wchk      <= '0;
`ifdef LOADER_VERIFY_EN
      mem_re    <= 1'b0;
      rchk      <= '0;
      base_q    <= '0;
      len_q     <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            done  <= 1'b0;
            error <= 1'b0;
            wchk  <= '0;
`ifdef LOADER_VERIFY_EN
            rchk   <= '0;
            base_q <= base_addr;
            len_q  <= length;
`endif
            if (length > LEN_W'(MAX_LEN)) begin
              state <= S_DONE;
              done  <= 1'b1;
              error <= 1'b1;
            end else if (length == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_WRITE;
              busy      <= 1'b1;
              din_ready <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= ag_addr;
            mem_wdata <= din;
            wchk      <= wchk ^ din;
            if (ag_last) begin
              din_ready <= 1'b0;
              state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
`ifdef LOADER_VERIFY_EN
          state    <= S_VERIFY;
          mem_re   <= 1'b1;
          mem_addr <= base_q;
`else
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
`endif
        end
`ifdef LOADER_VERIFY_EN
        S_VERIFY: begin
          rchk <= rchk_next;
          if (ag_last) begin
            mem_re <= 1'b0;
            state  <= S_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            error  <= (rchk_next != wchk);
          end else begin
            mem_addr <= ag_next_addr;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_32x8_loader.sv
// Bench for ram_32x8_loader: table-driven and random loads against a RAM model and an address/data reference.
module tb_ram_32x8_loader;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] base_addr;
  logic [5:0] length;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       done;
  logic       error;

  ram_32x8_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  // 32x8 RAM with an optional corruption of one location on write
  logic [7:0] ram [32];
  logic       corrupt_en = 1'b0;
  logic [4:0] corrupt_addr = 5'd0;
  int unsigned cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we)
      ram[mem_addr] <= (corrupt_en && mem_addr == corrupt_addr) ? ~mem_wdata : mem_wdata;
  end
  assign mem_rdata = ram[mem_addr];

  typedef struct {
    logic [4:0]  addr;
    logic [7:0]  data;
    int unsigned cyc;
  } wr_t;

  typedef struct {
    logic [4:0]  base;
    logic [5:0]  len;
    int unsigned mode;
    int unsigned kind;
    logic        exp_err;
    int unsigned exp_writes;
  } vec_t;

  logic [7:0]  ref_ram [32];
  bit          ref_valid [32];
  logic [7:0]  tx_bytes [$];
  wr_t         exp_q [$];
  logic [4:0]  re_q [$];
  int unsigned cur_base;
  int unsigned we_count = 0;
  int unsigned we_base = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  vec_t        vecs [8];
  vec_t        rv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_we) begin
          we_count++;
          chk("we_re_exclusive", {31'd0, mem_re}, 0);
          if (exp_q.size() == 0) begin
            chk("we_unexpected", {31'd0, mem_we}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("we_addr", {27'd0, mem_addr}, {27'd0, e.addr});
            chk("we_data", {24'd0, mem_wdata}, {24'd0, e.data});
            chk("we_latency", cyc, e.cyc);
          end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          chk("we_missing", {31'd0, mem_we}, 1);
          e = exp_q.pop_front();
        end
        if (mem_re) re_q.push_back(mem_addr);
      end
    end
  endtask

  task automatic do_start(input logic [4:0] b, input logic [5:0] l);
    cur_base  = b;
    we_base   = we_count;
    re_q.delete();
    start     = 1'b1;
    base_addr = b;
    length    = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input int unsigned n, input int unsigned mode, input bit tail);
    int unsigned sent = 0;
    int unsigned k = 0;
    int unsigned a;
    while (sent < n && k < 4000) begin
      case (mode)
        0:       din_valid = 1'b1;
        1:       din_valid = (k % 3 == 0);
        default: din_valid = 1'($urandom_range(0, 1));
      endcase
      din = tx_bytes[sent];
      if (din_valid && din_ready) begin
        a = (cur_base + sent) % 32;
        exp_q.push_back('{5'(a), din, cyc + 1});
        ref_ram[a]   = (corrupt_en && 5'(a) == corrupt_addr) ? ~din : din;
        ref_valid[a] = 1'b1;
        sent++;
      end
      k++;
      @(negedge clk);
    end
    chk("feed_all_accepted", sent, n);
    if (tail) begin
      din_valid = 1'b1;
      din       = 8'hEE;
      chk("ready_low_after_last", {31'd0, din_ready}, 0);
    end
  endtask

  task automatic wait_done();
    int unsigned b = 0;
    while (!done && b < 500) begin
      @(negedge clk);
      b++;
    end
    chk("done_seen", {31'd0, done}, 1);
  endtask

  task automatic finish_checks(input string tag, input int unsigned b, input int unsigned l,
                               input int unsigned exp_w, input logic exp_e);
    int unsigned bad = 0;
    int unsigned exp_re = 0;
    logic        e = exp_e;
`ifdef LOADER_VERIFY_EN
    logic [7:0] xw = 8'h00;
    logic [7:0] xr = 8'h00;
    if (l >= 1 && l <= 32) begin
      for (int unsigned i = 0; i < l; i++) begin
        xw ^= tx_bytes[i];
        xr ^= ref_ram[(b + i) % 32];
      end
      e      = (xw != xr);
      exp_re = l;
    end
`endif
    chk({tag, "_done"}, {31'd0, done}, 1);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_error"}, {31'd0, error}, {31'd0, e});
    chk({tag, "_we_count"}, we_count - we_base, exp_w);
    chk({tag, "_writes_drained"}, exp_q.size(), 0);
    for (int unsigned i = 0; i < 32; i++)
      if (ref_valid[i] && ram[i] !== ref_ram[i]) bad++;
    chk({tag, "_ram"}, bad, 0);
    chk({tag, "_re_count"}, re_q.size(), exp_re);
    for (int unsigned i = 0; i < re_q.size() && i < exp_re; i++)
      chk({tag, "_re_addr"}, {27'd0, re_q[i]}, (b + i) % 32);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    tx_bytes.delete();
    for (int unsigned i = 0; i < 33; i++) begin
      case (v.kind)
        1:       tx_bytes.push_back(8'(8'h10 + i));
        2:       tx_bytes.push_back(8'(8'hA0 + i));
        default: tx_bytes.push_back(8'($urandom));
      endcase
    end
    do_start(v.base, v.len);
    if (v.len == 0 || v.len > 32) begin
      chk({tag, "_done_next"}, {31'd0, done}, 1);
      chk({tag, "_busy_low"}, {31'd0, busy}, 0);
    end else begin
      chk({tag, "_busy_high"}, {31'd0, busy}, 1);
      chk({tag, "_done_cleared"}, {31'd0, done}, 0);
      chk({tag, "_ready_high"}, {31'd0, din_ready}, 1);
      feed(v.len, v.mode, 1'b1);
      wait_done();
    end
    din_valid = 1'b0;
    finish_checks(tag, v.base, v.len, v.exp_writes, v.exp_err);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_din_ready"}, {31'd0, din_ready}, 0);
    chk({tag, "_mem_addr"}, {27'd0, mem_addr}, 0);
    chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 0);
    chk({tag, "_mem_re"}, {31'd0, mem_re}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_error"}, {31'd0, error}, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    din       = '0;
    din_valid = 1'b0;
    for (int unsigned i = 0; i < 32; i++) begin
      ref_ram[i]   = 8'h00;
      ref_valid[i] = 1'b0;
    end
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // base, len, valid mode (0 steady, 1 = 1,0,0 pattern, 2 random), byte kind, error, writes
    vecs[0] = '{5'd0,  6'd8,  0, 1, 1'b0, 8};
    vecs[1] = '{5'd30, 6'd4,  0, 2, 1'b0, 4};
    vecs[2] = '{5'd3,  6'd5,  1, 0, 1'b0, 5};
    vecs[3] = '{5'd9,  6'd33, 0, 0, 1'b1, 0};
    vecs[4] = '{5'd9,  6'd0,  0, 0, 1'b0, 0};
    vecs[5] = '{5'd17, 6'd32, 2, 0, 1'b0, 32};
    vecs[6] = '{5'd31, 6'd1,  0, 0, 1'b0, 1};
    vecs[7] = '{5'd12, 6'd63, 2, 0, 1'b1, 0};
    for (int unsigned i = 0; i < 8; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int unsigned i = 0; i < 4; i++) begin
      rv.base       = 5'($urandom_range(0, 31));
      rv.len        = 6'($urandom_range(1, 32));
      rv.mode       = 2;
      rv.kind       = 0;
      rv.exp_err    = 1'b0;
      rv.exp_writes = rv.len;
      run_vec(rv, $sformatf("rand%0d", i));
    end

    // Reset after 3 of 6 accepted bytes, then a normal load with a start pulse while busy
    tx_bytes.delete();
    for (int unsigned i = 0; i < 6; i++) tx_bytes.push_back(8'($urandom));
    do_start(5'd20, 6'd6);
    feed(3, 0, 1'b0);
    din_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outputs_zero("midreset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    tx_bytes.delete();
    tx_bytes.push_back(8'h5A);
    tx_bytes.push_back(8'hC3);
    do_start(5'd8, 6'd2);
    start     = 1'b1;
    base_addr = 5'd20;
    length    = 6'd3;
    @(negedge clk);
    start = 1'b0;
    chk("start_while_busy_busy", {31'd0, busy}, 1);
    chk("start_while_busy_ready", {31'd0, din_ready}, 1);
    feed(2, 0, 1'b1);
    wait_done();
    din_valid = 1'b0;
    finish_checks("after_reset", 8, 2, 2, 1'b0);
    chk("after_reset_ram8", {24'd0, ram[8]}, 32'h5A);
    chk("after_reset_ram9", {24'd0, ram[9]}, 32'hC3);

`ifdef LOADER_VERIFY_EN
    rv = '{5'd4, 6'd4, 0, 0, 1'b0, 4};
    run_vec(rv, "verify_clean");
    chk("verify_clean_flag", {31'd0, error}, 0);
    corrupt_en   = 1'b1;
    corrupt_addr = 5'd5;
    run_vec(rv, "verify_corrupt");
    chk("verify_corrupt_flag", {31'd0, error}, 1);
    corrupt_en = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
